lsu_mem_initiator: RTL
======================

Name: lsu_mem_initiator

Overview:
- Core-side load/store unit that initiates requests toward the word-organised data memory.
- Accepts one load or store per handshake from the execute stage, using the RISC-V funct3 encoding.
- Issues word-aligned bus transactions with byte enables, waits for the memory acknowledge, then returns extracted and extended load data or a completion/error response.
- Sits between the execute/writeback stages and the data memory port.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width; fixed at 32 (4 byte lanes)
TIMEOUT_CYCLES, 255, max cycles mem_req may wait for mem_ack before abort; 8-bit counter

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
req_valid  in  1  core request valid
req_ready  out  1  unit can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
resp_err  out  1  qualifies resp_valid: illegal funct3, misaligned access, or timeout
mem_req  out  1  bus request, held until ack
mem_we  out  1  bus write
mem_addr  out  ADDR_WIDTH  word address, bits [1:0] = 0
mem_be  out  4  byte enables, bit i = byte lane i
mem_wdata  out  DATA_WIDTH  lane-aligned store data
mem_ack  in  1  memory completes the current beat; mem_rdata valid in the same cycle
mem_rdata  in  DATA_WIDTH  read word

Behaviour:
- Reset (rst_n low at posedge): state IDLE. req_ready=1. resp_valid=0, resp_err=0, resp_rdata=0. mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0. Timeout counter=0.
  - Reset mid-transaction abandons the transaction with no response.
- Handshake:
  - A request is accepted when req_valid and req_ready are both high. req_ready is high only in IDLE.
  - All request fields are latched at accept. No response backpressure.
- States:
  - IDLE: on accept, go to ERR if funct3 is illegal, else ACC0.
    - Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010.
  - ACC0: mem_req=1, first-word beat. On mem_ack: go to ACC1 if the access spans two words, else RESP.
  - ACC1: mem_req=1, mem_addr = first word + 4. On mem_ack, go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0 for one cycle, then IDLE.
- Bus rules:
  - mem_addr, mem_we, mem_be and mem_wdata are stable while mem_req is high.
  - mem_req drops in the cycle after the ack.
  - mem_ack while mem_req is low is ignored.
- Lanes (off = addr[1:0]):
  - Size mask: 0001 (b), 0011 (h), 1111 (w).
  - Beat 0: mem_be = (mask << off)[3:0]; mem_wdata = wdata << 8*off.
  - Beat 1: mem_be = mask >> (4-off); mem_wdata = wdata >> 8*(4-off).
  - Loads: mem_be is driven the same way; mem_we=0.
- Load extraction:
  - Form {beat1_data, beat0_data} (beat1_data=0 if single beat), shift right by 8*off, take the low 8/16/32 bits.
  - Sign-extend for 000/001; zero-extend for 100/101.
- Spanning:
  - Spans when off + size_bytes > 4: halfword at off=3, word at off≠0.
  - Halfword at off=1 stays in one word (be=0110).
- Timeout:
  - The counter clears on entry to ACC0/ACC1 and increments each cycle mem_req is high without ack.
  - At TIMEOUT_CYCLES: drop mem_req, go to ERR.
  - A timeout in ACC1 after a completed store beat 0 leaves the partial write in memory; resp_err is still reported.
- Latency: aligned access with ack k cycles after mem_req rises gives resp_valid at accept+k+2. Ack in the first request cycle (k=0) gives 2.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: spanning accesses are split into ACC0+ACC1 as described.
- Undefined: a spanning access goes IDLE→ERR with no bus activity; ACC1 and the beat-1 lane logic are not built.
- Non-spanning unaligned accesses (e.g. halfword at off=1) behave identically in both builds.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> req_ready=1, mem_req=0, resp_valid=0.
- Store byte 0xA5 to 0x0000_0013, ack after 3 cycles -> mem_addr=0x10, be=1000, wdata[31:24]=0xA5; resp_valid 5 cycles after accept, err=0.
- Load halfword signed at 0x22, mem_rdata=0x8001_7FFF, ack immediately -> be=1100, resp_rdata=0xFFFF_8001; lhu returns 0x0000_8001.
- Load word at 0x0000_0006 with macro defined, beat0 rdata=0x4433_2211, beat1 rdata=0x8877_6655 -> beats 0x04 (be=1100) and 0x08 (be=0011); resp_rdata=0x6655_4433. Without macro: resp_err=1, no mem_req.
- Illegal funct3=011 load, and a store with funct3=100 -> resp_err=1 one cycle after accept, mem_req never asserted.
- Load with mem_ack held low, TIMEOUT_CYCLES=255 -> mem_req drops after 255 request cycles, resp_err=1, resp_rdata=0; an ack arriving afterwards is ignored.

Source files
------------

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: core-side load/store unit for a word-organised data memory.
// One load or store is accepted per handshake (RISC-V funct3 sizes), turned into
// one or two word-aligned bus beats with byte enables, and answered with a single
// resp_valid pulse carrying extended load data or an error flag.
//
// Build option LSU_MISALIGN_SPLIT_EN:
//   defined   - accesses straddling a word boundary are split into two beats
//   undefined - such accesses are rejected with resp_err and no bus activity;
//               the second-beat state and lane logic are not built

// Per-byte-lane write steering. Lane i carries source byte (i - off) mod 4;
// the first beat owns lanes at or above the offset, the second beat owns the
// lanes below it that wrapped into the next word.
module lsu_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0]  off,
`ifdef LSU_MISALIGN_SPLIT_EN
    input  logic        beat1,
`endif
    input  logic [3:0]  mask,
    input  logic [31:0] wdata,
    output logic        be,
    output logic [7:0]  lane_data
);
    localparam logic [1:0] IDX = 2'(LANE);

    logic [1:0] src;
    logic       active;

    // Select which request byte lands on this lane and whether the lane is live
    always_comb begin
        src = IDX - off;
`ifdef LSU_MISALIGN_SPLIT_EN
        active = beat1 ? (IDX < off) : (IDX >= off);
`else
        active = (IDX >= off);
`endif
        be        = active & mask[src];
        lane_data = active ? wdata[{src, 3'b000} +: 8] : 8'h00;
    end
endmodule

module lsu_mem_initiator #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // execute-stage request
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    // writeback response
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    // data memory port
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int NUM_LANES = DATA_WIDTH / 8;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ACC0 = 3'd1;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic [2:0] S_ACC1 = 3'd2;
`endif
    localparam logic [2:0] S_RESP = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    // Last count value before the wait is abandoned; the request is held for
    // exactly TIMEOUT_CYCLES cycles when no ack arrives.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [2:0]            state;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [7:0]            tcnt;
    logic [DATA_WIDTH-1:0] beat0_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic                  spans_q;
    logic [DATA_WIDTH-1:0] beat1_q;
`endif

    logic                  in_legal;
    logic                  in_spans;
    logic [3:0]            in_size;

    logic [3:0]                  size_mask;
    logic                        beat1;
    logic [ADDR_WIDTH-1:0]       word_addr;
    logic [NUM_LANES-1:0]        lane_be;
    logic [NUM_LANES-1:0][7:0]   lane_wd;

    logic [2*DATA_WIDTH-1:0]     pair;
    logic [DATA_WIDTH-1:0]       win;
    logic [DATA_WIDTH-1:0]       load_data;

    assign req_ready = (state == S_IDLE);

    // Classify the incoming request: funct3 legality and word-boundary crossing
    always_comb begin
        case (req_funct3)
            3'b000, 3'b001, 3'b010: in_legal = 1'b1;
            3'b100, 3'b101:         in_legal = !req_we;   // unsigned forms are loads only
            default:                in_legal = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'b00:   in_size = 4'd1;
            2'b01:   in_size = 4'd2;
            default: in_size = 4'd4;
        endcase
        in_spans = ({2'b00, req_addr[1:0]} + in_size) > 4'd4;
    end

    // Control FSM, request latch, beat data capture and ack timeout counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            tcnt    <= 8'd0;
            beat0_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            spans_q <= 1'b0;
            beat1_q <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        tcnt    <= 8'd0;
                        beat0_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
                        spans_q <= in_spans;
                        beat1_q <= '0;
                        state   <= in_legal ? S_ACC0 : S_ERR;
`else
                        state   <= (in_legal && !in_spans) ? S_ACC0 : S_ERR;
`endif
                    end
                end
                S_ACC0: begin
                    if (mem_ack) begin
                        beat0_q <= mem_rdata;
                        tcnt    <= 8'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
                        state   <= spans_q ? S_ACC1 : S_RESP;
`else
                        state   <= S_RESP;
`endif
                    end else if (tcnt == TO_LAST) begin
                        state <= S_ERR;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                S_ACC1: begin
                    // a timeout here leaves any first-beat store in memory
                    if (mem_ack) begin
                        beat1_q <= mem_rdata;
                        state   <= S_RESP;
                    end else if (tcnt == TO_LAST) begin
                        state <= S_ERR;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
`endif
                S_RESP:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Access-size byte mask from the latched funct3
    always_comb begin
        case (f3_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            lsu_lane #(.LANE(gi)) u_lane (
                .off       (addr_q[1:0]),
`ifdef LSU_MISALIGN_SPLIT_EN
                .beat1     (beat1),
`endif
                .mask      (size_mask),
                .wdata     (wdata_q),
                .be        (lane_be[gi]),
                .lane_data (lane_wd[gi])
            );
        end
    endgenerate

    // Bus drive: fields come only from latched state so they stay stable
    // for the whole beat, and read as zero whenever no request is up
    always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
        beat1   = (state == S_ACC1);
        mem_req = (state == S_ACC0) || (state == S_ACC1);
`else
        beat1   = 1'b0;
        mem_req = (state == S_ACC0);
`endif
        word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = '0;
        if (mem_req) begin
            mem_addr = beat1 ? (word_addr + ADDR_WIDTH'(4)) : word_addr;
            mem_we   = we_q;
            mem_be   = lane_be;
            if (we_q) mem_wdata = lane_wd;
        end
    end

    // Load extraction from the captured beat pair, then size/sign extension
    always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
        pair = {beat1_q, beat0_q};
`else
        pair = {{DATA_WIDTH{1'b0}}, beat0_q};
`endif
        win = DATA_WIDTH'(pair >> {addr_q[1:0], 3'b000});
        case (f3_q)
            3'b000:  load_data = {{24{win[7]}}, win[7:0]};
            3'b001:  load_data = {{16{win[15]}}, win[15:0]};
            3'b100:  load_data = {24'h000000, win[7:0]};
            3'b101:  load_data = {16'h0000, win[15:0]};
            default: load_data = win;
        endcase
    end

    // One-cycle response; data only for successful loads
    always_comb begin
        resp_valid = (state == S_RESP) || (state == S_ERR);
        resp_err   = (state == S_ERR);
        resp_rdata = ((state == S_RESP) && !we_q) ? load_data : '0;
    end
endmodule
